// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light lamp monitor: lamp codes, checker
// states, per-cycle checker events and the fault flag layout.
package semaforo_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    localparam int FLT_CODE  = 0;
    localparam int FLT_ORDER = 1;
    localparam int FLT_SHORT = 2;
    localparam int FLT_LONG  = 3;

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_GREEN,
        ST_YELLOW,
        ST_RED
    } chk_state_t;

    // At most one thing can happen per channel per cycle, so faults and the
    // red->green completion share a single event code.
    typedef enum logic [2:0] {
        EV_NONE,
        EV_CODE,
        EV_LONG,
        EV_ORDER,
        EV_SHORT,
        EV_RED2GREEN
    } chk_event_t;

    function automatic logic [3:0] event_flags(input chk_event_t e);
        logic [3:0] f;
        f = '0;
        case (e)
            EV_CODE:  f[FLT_CODE]  = 1'b1;
            EV_LONG:  f[FLT_LONG]  = 1'b1;
            EV_ORDER: f[FLT_ORDER] = 1'b1;
            EV_SHORT: f[FLT_SHORT] = 1'b1;
            default:  f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/semaforo_lamp_check.sv
// One-channel lamp protocol checker: tracks phase and dwell, and reports one
// event per sampled code (a fault, a red->green completion, or nothing).
module semaforo_lamp_check
    import semaforo_pkg::*;
#(
    parameter int GREEN_CYC  = 2,
    parameter int YELLOW_CYC = 4,
    parameter int RED_CYC    = 3,
    parameter int DW         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_lamp,
    output chk_event_t o_event
);

    chk_state_t    r_state;
    logic [DW-1:0] r_dwell;
    logic          r_first;

    chk_state_t    w_state_nxt;
    logic [DW-1:0] w_dwell_nxt;
    logic          w_first_nxt;
    chk_state_t    w_code;
    logic [DW-1:0] w_req;

    function automatic logic [DW-1:0] sat_inc(input logic [DW-1:0] v);
        return (v == {DW{1'b1}}) ? v : v + DW'(1);
    endfunction

    function automatic logic [DW-1:0] req_dwell(input chk_state_t s);
        case (s)
            ST_GREEN:  return DW'(GREEN_CYC);
            ST_YELLOW: return DW'(YELLOW_CYC);
            ST_RED:    return DW'(RED_CYC);
            default:   return '0;
        endcase
    endfunction

    // Invalid codes (000 or multi-hot) map to ST_SYNC.
    function automatic chk_state_t code2state(input logic [2:0] c);
        case (c)
            LAMP_GREEN:  return ST_GREEN;
            LAMP_YELLOW: return ST_YELLOW;
            LAMP_RED:    return ST_RED;
            default:     return ST_SYNC;
        endcase
    endfunction

    function automatic chk_state_t successor(input chk_state_t s);
        case (s)
            ST_GREEN:  return ST_YELLOW;
            ST_YELLOW: return ST_RED;
            ST_RED:    return ST_GREEN;
            default:   return ST_SYNC;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_SYNC;
            r_dwell <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dwell <= w_dwell_nxt;
            r_first <= w_first_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_first_nxt = r_first;
        o_event     = EV_NONE;
        w_code      = code2state(i_lamp);
        w_req       = req_dwell(r_state);

        if (w_code == ST_SYNC) begin
            o_event     = EV_CODE;
            w_state_nxt = ST_SYNC;
            w_dwell_nxt = '0;
            w_first_nxt = 1'b0;
        end else if (r_state == ST_SYNC) begin
            // First phase after resync: its length before us is unknown.
            w_state_nxt = w_code;
            w_dwell_nxt = DW'(1);
            w_first_nxt = 1'b1;
        end else if (w_code == r_state) begin
            if (r_dwell == w_req) begin
                o_event     = EV_LONG;
                w_state_nxt = ST_SYNC;
                w_dwell_nxt = '0;
                w_first_nxt = 1'b0;
            end else begin
                w_dwell_nxt = sat_inc(r_dwell);
            end
        end else if (w_code != successor(r_state)) begin
            o_event     = EV_ORDER;
            w_state_nxt = ST_SYNC;
            w_dwell_nxt = '0;
            w_first_nxt = 1'b0;
        end else if ((r_dwell < w_req) && !r_first) begin
            o_event     = EV_SHORT;
            w_state_nxt = ST_SYNC;
            w_dwell_nxt = '0;
            w_first_nxt = 1'b0;
        end else begin
            if (r_state == ST_RED) begin
                o_event = EV_RED2GREEN;
            end
            w_state_nxt = w_code;
            w_dwell_nxt = DW'(1);
            w_first_nxt = 1'b0;
        end
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Passive lamp-bus monitor: two channel checkers feeding sticky fault flags,
// a registered interrupt and a completed-cycle counter for channel A.
module semaforo_monitor
    import semaforo_pkg::*;
#(
    parameter int GREEN_CYC  = 2,
    parameter int YELLOW_CYC = 4,
    parameter int RED_CYC    = 3,
    parameter int DW         = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] a_lamp,
    input  logic [2:0] b_lamp,
    input  logic       clr,
    output logic [3:0] fault_a,
    output logic [3:0] fault_b,
    output logic       fault_irq,
    output logic [7:0] cycles_a
);

    chk_event_t w_evt_a;
    chk_event_t w_evt_b;

    logic [3:0] r_fault_a;
    logic [3:0] r_fault_b;
    logic       r_irq;
    logic [7:0] r_cycles_a;

    semaforo_lamp_check #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .RED_CYC    (RED_CYC),
        .DW         (DW)
    ) u_chk_a (
        .clk     (clk),
        .rst     (rst),
        .i_lamp  (a_lamp),
        .o_event (w_evt_a)
    );

    semaforo_lamp_check #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .RED_CYC    (RED_CYC),
        .DW         (DW)
    ) u_chk_b (
        .clk     (clk),
        .rst     (rst),
        .i_lamp  (b_lamp),
        .o_event (w_evt_b)
    );

    // A new raise is ORed after the clear so it survives a simultaneous clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_a  <= '0;
            r_fault_b  <= '0;
            r_irq      <= 1'b0;
            r_cycles_a <= '0;
        end else begin
            r_fault_a <= (clr ? 4'b0000 : r_fault_a) | event_flags(w_evt_a);
            r_fault_b <= (clr ? 4'b0000 : r_fault_b) | event_flags(w_evt_b);
            r_irq     <= |{r_fault_a, r_fault_b};
            if (w_evt_a == EV_RED2GREEN) begin
                r_cycles_a <= r_cycles_a + 8'd1;
            end
        end
    end

    assign fault_a   = r_fault_a;
    assign fault_b   = r_fault_b;
    assign fault_irq = r_irq;
    assign cycles_a  = r_cycles_a;

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: directed protocol scenarios followed
// by randomized lamp streams, checked against a phase/run-length model.
module tb_semaforo_monitor;

    localparam int GREEN_CYC  = 2;
    localparam int YELLOW_CYC = 4;
    localparam int RED_CYC    = 3;
    localparam int DW         = 4;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [2:0] a_lamp = 3'b000;
    logic [2:0] b_lamp = 3'b000;
    logic [3:0] fault_a;
    logic [3:0] fault_b;
    logic       fault_irq;
    logic [7:0] cycles_a;

    always #5 clk = ~clk;

    semaforo_monitor #(
        .GREEN_CYC  (GREEN_CYC),
        .YELLOW_CYC (YELLOW_CYC),
        .RED_CYC    (RED_CYC),
        .DW         (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_lamp    (a_lamp),
        .b_lamp    (b_lamp),
        .clr       (clr),
        .fault_a   (fault_a),
        .fault_b   (fault_b),
        .fault_irq (fault_irq),
        .cycles_a  (cycles_a)
    );

    typedef struct packed {
        logic [3:0] fa;
        logic [3:0] fb;
        logic       irq;
        logic [7:0] cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: per channel, the lamp of the current run (0 = unsynced),
    // how long it has lasted, and whether it is the exempt first run.
    logic [2:0] m_code[2];
    int         m_len[2];
    bit         m_ex[2];
    logic [3:0] m_flag[2];
    logic       m_irq;
    logic [7:0] m_cyc;

    // Random stream generator state.
    logic [2:0] g_code[2];
    int         g_rem[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int req_of(input logic [2:0] c);
        case (c)
            G:       return GREEN_CYC;
            Y:       return YELLOW_CYC;
            R:       return RED_CYC;
            default: return 0;
        endcase
    endfunction

    function automatic logic [2:0] next_color(input logic [2:0] c);
        return {c[1:0], c[2]};
    endfunction

    function automatic logic [3:0] model_chan(input int ch, input logic [2:0] s, output bit r2g);
        logic [3:0] raise;
        int req;
        raise = 4'b0000;
        r2g   = 1'b0;
        req   = req_of(m_code[ch]);
        if ($countones(s) != 1) begin
            raise = 4'b0001;
            m_code[ch] = 3'b000;
        end else if (m_code[ch] == 3'b000) begin
            m_code[ch] = s;
            m_len[ch]  = 1;
            m_ex[ch]   = 1'b1;
        end else if (s == m_code[ch]) begin
            if (m_len[ch] == req) begin
                raise = 4'b1000;
                m_code[ch] = 3'b000;
            end else begin
                m_len[ch]++;
            end
        end else if (s != next_color(m_code[ch])) begin
            raise = 4'b0010;
            m_code[ch] = 3'b000;
        end else if (m_len[ch] < req && !m_ex[ch]) begin
            raise = 4'b0100;
            m_code[ch] = 3'b000;
        end else begin
            r2g = (m_code[ch] == R);
            m_code[ch] = s;
            m_len[ch]  = 1;
            m_ex[ch]   = 1'b0;
        end
        return raise;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_code[c] = 3'b000;
            m_len[c]  = 0;
            m_ex[c]   = 1'b0;
            m_flag[c] = 4'b0000;
        end
        m_irq = 1'b0;
        m_cyc = 8'd0;
    endtask

    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic c);
        logic [3:0] ra, rb;
        bit r2g_a, r2g_b;
        exp_t e;
        @(negedge clk);
        rst    = 1'b0;
        a_lamp = a;
        b_lamp = b;
        clr    = c;
        ra = model_chan(0, a, r2g_a);
        rb = model_chan(1, b, r2g_b);
        m_irq = |(m_flag[0] | m_flag[1]);
        m_flag[0] = (c ? 4'b0000 : m_flag[0]) | ra;
        m_flag[1] = (c ? 4'b0000 : m_flag[1]) | rb;
        if (r2g_a) m_cyc = m_cyc + 8'd1;
        e.fa = m_flag[0];
        e.fb = m_flag[1];
        e.irq = m_irq;
        e.cyc = m_cyc;
        sb.push_back(e);
    endtask

    task automatic drive_n(input logic [2:0] a, input logic [2:0] b, input int n);
        for (int i = 0; i < n; i++) drive(a, b, 1'b0);
    endtask

    // Reset is asserted away from the active edge so its asynchronous effect
    // is observable before the next rising edge.
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst    = 1'b1;
        clr    = 1'b0;
        a_lamp = 3'b000;
        b_lamp = 3'b000;
        model_reset();
        e = '0;
        sb.push_back(e);
        #1;
        chk("async_rst_fault_a", fault_a, 0);
        chk("async_rst_fault_b", fault_b, 0);
        chk("async_rst_irq", fault_irq, 0);
        chk("async_rst_cycles", cycles_a, 0);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [2:0] gen_lamp(input int ch);
        int r;
        if ($urandom_range(0, 59) == 0) return 3'($urandom_range(0, 7));
        if (g_rem[ch] <= 0) begin
            if ($urandom_range(0, 14) == 0) g_code[ch] = 3'b001 << $urandom_range(0, 2);
            else g_code[ch] = next_color(g_code[ch]);
            r = $urandom_range(0, 9);
            g_rem[ch] = req_of(g_code[ch]);
            if (r == 0 && g_rem[ch] > 1) g_rem[ch]--;
            else if (r == 1) g_rem[ch]++;
        end
        g_rem[ch]--;
        return g_code[ch];
    endfunction

    // Monitor: one expectation per rising edge, compared shortly after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("fault_a", fault_a, e.fa);
                chk("fault_b", fault_b, e.fb);
                chk("fault_irq", fault_irq, e.irq);
                chk("cycles_a", cycles_a, e.cyc);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Legal sequence on both channels for three full periods.
        do_reset();
        for (int p = 0; p < 3; p++) begin
            drive_n(G, G, 2);
            drive_n(Y, Y, 4);
            drive_n(R, R, 3);
        end
        drive(G, G, 1'b0);
        after_edge();
        chk("t1_cycles_a", cycles_a, 3);
        chk("t1_irq", fault_irq, 0);

        // Short yellow on A, then a clean period after resync.
        do_reset();
        drive_n(G, G, 2);
        drive_n(Y, Y, 3);
        drive(R, Y, 1'b0);
        after_edge();
        chk("t2_short", fault_a, 4'b0100);
        chk("t2_irq_lag", fault_irq, 0);
        drive(R, R, 1'b0);
        after_edge();
        chk("t2_irq", fault_irq, 1);
        drive_n(R, R, 2);
        drive_n(G, G, 2);
        drive_n(Y, Y, 4);
        drive_n(R, R, 3);
        drive(G, G, 1'b0);
        after_edge();
        chk("t2_sticky", fault_a, 4'b0100);
        chk("t2_b_clean", fault_b, 0);

        // B holds green one cycle too long after a legal exempt red.
        do_reset();
        drive_n(G, R, 2);
        drive(Y, R, 1'b0);
        drive_n(Y, G, 3);
        after_edge();
        chk("t3_long", fault_b, 4'b1000);
        chk("t3_a_clean", fault_a, 0);

        // A skips yellow, then shows a multi-hot code.
        do_reset();
        drive_n(G, G, 2);
        drive(R, Y, 1'b0);
        after_edge();
        chk("t4_order", fault_a, 4'b0010);
        drive(3'b011, Y, 1'b0);
        after_edge();
        chk("t4_code", fault_a, 4'b0011);

        // Clear in a quiet cycle, then clear colliding with a new code fault.
        drive(G, Y, 1'b1);
        after_edge();
        chk("t5_clr", fault_a, 0);
        drive(G, Y, 1'b0);
        after_edge();
        chk("t5_irq_clear", fault_irq, 0);
        drive(3'b000, R, 1'b1);
        after_edge();
        chk("t5_clr_vs_raise", fault_a, 4'b0001);
        chk("t5_b_clean", fault_b, 0);

        // Reset in the middle of yellow, restart from a short red.
        do_reset();
        drive_n(G, G, 2);
        drive_n(Y, Y, 2);
        do_reset();
        drive(R, R, 1'b0);
        drive_n(G, G, 2);
        drive_n(Y, Y, 4);
        drive_n(R, R, 3);
        drive(G, G, 1'b0);
        after_edge();
        chk("t6_cycles_a", cycles_a, 2);
        chk("t6_faults", {fault_a, fault_b}, 0);

        // Randomized streams with occasional clear and reset.
        g_code[0] = R;
        g_code[1] = Y;
        g_rem[0]  = 0;
        g_rem[1]  = 2;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 699) == 0) do_reset();
            else drive(gen_lamp(0), gen_lamp(1), ($urandom_range(0, 24) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
